// File: rtl/regfile_2r1w_sb_if.sv
// rtl/regfile_2r1w_sb_if.sv - write, reserve, read and status bundle of the 2R1W scoreboarded register file
interface regfile_2r1w_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              busy_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_b;
    logic              rsv_err;
    logic [ADDR_W:0]   pending_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
               rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, busy_a, rd_data_b, busy_b, rsv_err, pending_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
               rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, busy_a, rd_data_b, busy_b, rsv_err, pending_cnt
    );
endinterface

// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - 2 registered read ports, 1 write port, write-first bypass, per-register busy scoreboard
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_2r1w_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic               clk,
    input  logic               clr,
    regfile_2r1w_sb_if.slave   bus
);

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     cnt_nxt;

    logic wr_in, rsv_in, rd_in_a, rd_in_b;
    logic wr_ok, rsv_ok, rd_ok_a, rd_ok_b;
    logic rsv_err_nxt;

    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              rbusy_a, rbusy_b;

    // A power-of-two bank has no out-of-range addresses, so skip the compare entirely.
    generate
        if (NUM_REGS == (1 << ADDR_W)) begin : g_full
            assign wr_in   = 1'b1;
            assign rsv_in  = 1'b1;
            assign rd_in_a = 1'b1;
            assign rd_in_b = 1'b1;
        end else begin : g_part
            assign wr_in   = {1'b0, bus.wr_addr}   < (ADDR_W+1)'(NUM_REGS);
            assign rsv_in  = {1'b0, bus.rsv_addr}  < (ADDR_W+1)'(NUM_REGS);
            assign rd_in_a = {1'b0, bus.rd_addr_a} < (ADDR_W+1)'(NUM_REGS);
            assign rd_in_b = {1'b0, bus.rd_addr_b} < (ADDR_W+1)'(NUM_REGS);
        end
    endgenerate

    assign wr_ok   = bus.wr_en  && wr_in  && !(R0_ZERO && (bus.wr_addr  == '0));
    assign rsv_ok  = bus.rsv_en && rsv_in && !(R0_ZERO && (bus.rsv_addr == '0));
    assign rd_ok_a = rd_in_a && !(R0_ZERO && (bus.rd_addr_a == '0));
    assign rd_ok_b = rd_in_b && !(R0_ZERO && (bus.rd_addr_b == '0));

    // Reserve is applied after the write clear so a new reservation wins over a retiring result.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[bus.rsv_addr] = 1'b1;
        end
    end

    assign rsv_err_nxt = rsv_ok && busy[bus.rsv_addr];

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    always_comb begin
        rdata_a = '0;
        rbusy_a = 1'b0;
        if (rd_ok_a) begin
            rdata_a = (wr_ok && (bus.wr_addr == bus.rd_addr_a)) ? bus.wr_data : regs[bus.rd_addr_a];
            rbusy_a = busy_nxt[bus.rd_addr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        rbusy_b = 1'b0;
        if (rd_ok_b) begin
            rdata_b = (wr_ok && (bus.wr_addr == bus.rd_addr_b)) ? bus.wr_data : regs[bus.rd_addr_b];
            rbusy_b = busy_nxt[bus.rd_addr_b];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy            <= '0;
            bus.rd_data_a   <= '0;
            bus.busy_a      <= 1'b0;
            bus.rd_data_b   <= '0;
            bus.busy_b      <= 1'b0;
            bus.rsv_err     <= 1'b0;
            bus.pending_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                    regs[i] <= bus.wr_data;
                end
            end
            busy            <= busy_nxt;
            bus.rsv_err     <= rsv_err_nxt;
            bus.pending_cnt <= cnt_nxt;
            if (bus.rd_en_a) begin
                bus.rd_data_a <= rdata_a;
                bus.busy_a    <= rbusy_a;
            end
            if (bus.rd_en_b) begin
                bus.rd_data_b <= rdata_b;
                bus.busy_b    <= rbusy_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb/tb_regfile_2r1w_sb.sv - directed self-checking bench for regfile_2r1w_sb
module tb_regfile_2r1w_sb;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic clk;
    logic clr;
    int   total;
    int   passed;

    regfile_2r1w_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    regfile_2r1w_sb #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rsv_en    = 1'b0;
        bus.rsv_addr  = '0;
        bus.rd_en_a   = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_en_b   = 1'b0;
        bus.rd_addr_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_a"}, bus.rd_data_a, 32'h0);
        chk({tag, "_busy_a"}, 32'(bus.busy_a), 32'h0);
        chk({tag, "_rd_b"}, bus.rd_data_b, 32'h0);
        chk({tag, "_busy_b"}, 32'(bus.busy_b), 32'h0);
        chk({tag, "_rsv_err"}, 32'(bus.rsv_err), 32'h0);
        chk({tag, "_cnt"}, 32'(bus.pending_cnt), 32'h0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        clr    = 1'b1;
        idle();
        tick();
        tick();
        chk_all_zero("reset");
        clr = 1'b0;

        // write R5 then read it on port A
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'hDEADBEEF;
        tick();
        idle();
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd5;
        tick();
        chk("rd_r5", bus.rd_data_a, 32'hDEADBEEF);
        chk("rd_r5_busy", 32'(bus.busy_a), 32'h0);

        // rd_en low holds the previous data even though R5 changes
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h00000001;
        tick();
        chk("hold_a", bus.rd_data_a, 32'hDEADBEEF);

        // write-first bypass on both ports at the same address
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 32'h12345678;
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd3;
        bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'd3;
        tick();
        chk("bypass_b", bus.rd_data_b, 32'h12345678);
        chk("bypass_a", bus.rd_data_a, 32'h12345678);

        // reserve R7 while reading it: busy reflects the same-cycle reserve
        idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd7;
        tick();
        chk("rsv7_busy_a", 32'(bus.busy_a), 32'h1);
        chk("rsv7_cnt", 32'(bus.pending_cnt), 32'h1);
        chk("rsv7_err", 32'(bus.rsv_err), 32'h0);

        // second reserve of R7 raises a one-cycle error
        idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 4'd7;
        tick();
        chk("rsv7_again_err", 32'(bus.rsv_err), 32'h1);
        chk("rsv7_again_cnt", 32'(bus.pending_cnt), 32'h1);
        idle();
        tick();
        chk("rsv_err_pulse_end", 32'(bus.rsv_err), 32'h0);

        // writeback of R7 clears busy
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 32'h000000AA;
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd7;
        tick();
        chk("wb7_data", bus.rd_data_a, 32'h000000AA);
        chk("wb7_busy", 32'(bus.busy_a), 32'h0);
        chk("wb7_cnt", 32'(bus.pending_cnt), 32'h0);

        // simultaneous reserve and write of R2: reservation wins, data written
        idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 4'd2;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 32'h00000055;
        bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'd2;
        tick();
        chk("rw2_data_b", bus.rd_data_b, 32'h00000055);
        chk("rw2_busy_b", 32'(bus.busy_b), 32'h1);
        chk("rw2_cnt", 32'(bus.pending_cnt), 32'h1);
        chk("rw2_err", 32'(bus.rsv_err), 32'h0);
        idle();
        bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'd2;
        tick();
        chk("rd2_data_b", bus.rd_data_b, 32'h00000055);
        chk("rd2_busy_b", 32'(bus.busy_b), 32'h1);

        // register 0: write, reserve, then read
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 32'hFFFFFFFF;
        tick();
        idle();
        bus.rsv_en = 1'b1; bus.rsv_addr = 4'd0;
        tick();
        chk("r0_rsv_err", 32'(bus.rsv_err), 32'h0);
        chk("r0_rsv_cnt", 32'(bus.pending_cnt), R0Z ? 32'h1 : 32'h2);
        idle();
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd0;
        tick();
        chk("r0_rd_a", bus.rd_data_a, R0Z ? 32'h0 : 32'hFFFFFFFF);
        chk("r0_busy_a", 32'(bus.busy_a), R0Z ? 32'h0 : 32'h1);

        // asynchronous clear between edges
        idle();
        #2;
        clr = 1'b1;
        #1;
        chk_all_zero("async_clr");
        clr = 1'b0;
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd5;
        bus.rd_en_b = 1'b1; bus.rd_addr_b = 4'd2;
        tick();
        chk_all_zero("post_clr");
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 32'hCAFEF00D;
        tick();
        idle();
        bus.rd_en_a = 1'b1; bus.rd_addr_a = 4'd9;
        tick();
        chk("post_clr_wr9", bus.rd_data_a, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
